// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// timer_pkg -- shared state encoding and count limits for timer_counter
// Rev 1.0
// ============================================================================
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [7:0] LSB_MAX      = 8'd99;
  localparam logic [7:0] MSB_MAX_A    = 8'd99;
  localparam logic [7:0] BLINK_THRESH = 8'd50;

endpackage
`default_nettype wire

// File: rtl/mod100_counter.sv
`default_nettype none
// ============================================================================
// mod100_counter -- 8-bit 0..99 counter with enable, sync clear and carry-out
// Rev 1.0
// ============================================================================
module mod100_counter
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic       i_clr,
  output logic [7:0] o_cnt,
  output logic [7:0] o_cnt_next,
  output logic       o_carry
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = 8'd0;
    end else if (i_en) begin
      cnt_d = (cnt_q == LSB_MAX) ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt      = cnt_q;
  assign o_cnt_next = cnt_d;
  assign o_carry    = i_en && !i_clr && (cnt_q == LSB_MAX);

endmodule
`default_nettype wire

// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
// timer_counter -- stopwatch (seconds.hundredths) with run/pause/clear control
// Rev 1.0
// ============================================================================
module timer_counter
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic       CLK,
  input  logic       nReset,
  input  logic       Tick100Hz,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Clear,
  input  logic       ModeSel,
  input  logic [2:0] TimeControl,
  output logic [7:0] MSB,
  output logic [7:0] LSB,
  output logic       Stopped,
  output logic       Running,
  output logic       Pulse1Hz
);

  localparam int              DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [2:0]       tc_q, tc_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             stopped_q, stopped_d;
  logic             running_q, running_d;
  logic             pulse_q, pulse_d;

  logic             cnt_en, cnt_clr;
  logic             lsb_carry, msb_carry_unused;
  logic [7:0]       lsb_next, msb_next_unused;
  logic [7:0]       msb_target;
  logic             at_term_next;

  assign msb_target   = mode_q ? ({5'd0, tc_q} + 8'd1) : MSB_MAX_A;
  // The increment that lands on xx.99 of the target second is the terminal edge.
  assign at_term_next = (LSB == (LSB_MAX - 8'd1)) && (MSB == msb_target);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    tc_d    = tc_q;
    div_d   = div_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    if (Clear) begin
      state_d = ST_IDLE;
      div_d   = '0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            state_d = ST_RUN;
            mode_d  = ModeSel;
            tc_d    = TimeControl;
          end
        end
        ST_RUN: begin
          if (Pause) begin
            state_d = ST_PAUSE;
          end else if (Tick100Hz) begin
            if (div_q == DIV_LAST) begin
              div_d  = '0;
              cnt_en = 1'b1;
              if (at_term_next) state_d = ST_DONE;
            end else begin
              div_d = div_q + 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (Start) state_d = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    running_d = (state_d == ST_RUN);
    stopped_d = (state_d == ST_DONE);
    pulse_d   = (lsb_next >= BLINK_THRESH) && ((state_d == ST_RUN) || (state_d == ST_PAUSE));
  end

  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      state_q   <= ST_IDLE;
      mode_q    <= 1'b0;
      tc_q      <= 3'd0;
      div_q     <= '0;
      stopped_q <= 1'b0;
      running_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      tc_q      <= tc_d;
      div_q     <= div_d;
      stopped_q <= stopped_d;
      running_q <= running_d;
      pulse_q   <= pulse_d;
    end
  end

  mod100_counter u_lsb (
    .clk        (CLK),
    .rst_n      (nReset),
    .i_en       (cnt_en),
    .i_clr      (cnt_clr),
    .o_cnt      (LSB),
    .o_cnt_next (lsb_next),
    .o_carry    (lsb_carry)
  );

  mod100_counter u_msb (
    .clk        (CLK),
    .rst_n      (nReset),
    .i_en       (lsb_carry),
    .i_clr      (cnt_clr),
    .o_cnt      (MSB),
    .o_cnt_next (msb_next_unused),
    .o_carry    (msb_carry_unused)
  );

  assign Stopped  = stopped_q;
  assign Running  = running_q;
  assign Pulse1Hz = pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
// ============================================================================
// tb_timer_counter -- scoreboard bench for timer_counter
// Rev 1.0
// ============================================================================
module tb_timer_counter;

  localparam int TICK_DIV = 1;

  logic       CLK = 1'b0;
  logic       nReset = 1'b0;
  logic       Tick100Hz = 1'b0;
  logic       Start = 1'b0;
  logic       Pause = 1'b0;
  logic       Clear = 1'b0;
  logic       ModeSel = 1'b0;
  logic [2:0] TimeControl = 3'd0;
  logic [7:0] MSB, LSB;
  logic       Stopped, Running, Pulse1Hz;

  int n_checks = 0;
  int n_errors = 0;
  logic [18:0] exp_q[$];

  // reference model: total hundredths elapsed, state 0=IDLE 1=RUN 2=PAUSE 3=DONE
  int m_state = 0, m_total = 0, m_div = 0, m_mode = 0, m_tc = 0;

  always #5 CLK = ~CLK;

  timer_counter #(.TICK_DIV(TICK_DIV)) dut (
    .CLK         (CLK),
    .nReset      (nReset),
    .Tick100Hz   (Tick100Hz),
    .Start       (Start),
    .Pause       (Pause),
    .Clear       (Clear),
    .ModeSel     (ModeSel),
    .TimeControl (TimeControl),
    .MSB         (MSB),
    .LSB         (LSB),
    .Stopped     (Stopped),
    .Running     (Running),
    .Pulse1Hz    (Pulse1Hz)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [18:0] model_out();
    logic run, stp, pls;
    logic [7:0] ms, ls;
    ms  = 8'(m_total / 100);
    ls  = 8'(m_total % 100);
    run = (m_state == 1);
    stp = (m_state == 3);
    pls = (ls >= 8'd50) && (m_state == 1 || m_state == 2);
    return {run, stp, pls, ms, ls};
  endfunction

  task automatic model_step(input bit st, input bit pa, input bit cl, input bit tk);
    int limit;
    if (cl) begin
      m_state = 0; m_total = 0; m_div = 0;
    end else begin
      case (m_state)
        0: if (st) begin m_state = 1; m_mode = int'(ModeSel); m_tc = int'(TimeControl); end
        1: begin
          if (pa) m_state = 2;
          else if (tk) begin
            m_div++;
            if (m_div == TICK_DIV) begin
              m_div = 0;
              m_total++;
              limit = (m_mode != 0 ? m_tc + 1 : 99) * 100 + 99;
              if (m_total == limit) m_state = 3;
            end
          end
        end
        2: if (st) m_state = 1;
        default: ;
      endcase
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_total = 0; m_div = 0; m_mode = 0; m_tc = 0;
  endtask

  task automatic cycle(input bit st, input bit pa, input bit cl, input bit tk);
    logic [18:0] obs;
    logic [18:0] exp;
    Start = st; Pause = pa; Clear = cl; Tick100Hz = tk;
    model_step(st, pa, cl, tk);
    exp_q.push_back(model_out());
    @(posedge CLK);
    #1;
    Start = 1'b0; Pause = 1'b0; Clear = 1'b0; Tick100Hz = 1'b0;
    obs = {Running, Stopped, Pulse1Hz, MSB, LSB};
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      check("cycle_outputs", 32'(obs), 32'(exp));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 1);
  endtask

  initial begin
    #12;
    check("reset_msb", 32'(MSB), 32'd0);
    check("reset_lsb", 32'(LSB), 32'd0);
    check("reset_flags", 32'({Stopped, Running, Pulse1Hz}), 32'd0);
    nReset = 1'b1;

    // ticks in IDLE are ignored
    ticks(5);

    // mode A, 150 ticks -> 1.50
    ModeSel = 1'b0;
    cycle(1, 0, 0, 0);
    ticks(150);
    check("a150_msb", 32'(MSB), 32'd1);
    check("a150_lsb", 32'(LSB), 32'd50);
    check("a150_pulse", 32'(Pulse1Hz), 32'd1);
    check("a150_running", 32'(Running), 32'd1);
    cycle(0, 0, 1, 0);

    // mode B, target 3.99; mode inputs changed after start must be ignored
    ModeSel = 1'b1; TimeControl = 3'd2;
    cycle(1, 0, 0, 0);
    ModeSel = 1'b0; TimeControl = 3'd7;
    ticks(398);
    check("b398_stopped", 32'(Stopped), 32'd0);
    ticks(1);
    check("b399_msb", 32'(MSB), 32'd3);
    check("b399_lsb", 32'(LSB), 32'd99);
    check("b399_stopped", 32'(Stopped), 32'd1);
    ticks(10);
    check("b_hold", 32'({MSB, LSB, Stopped}), {15'd0, 8'd3, 8'd99, 1'b1});
    cycle(1, 0, 0, 1);
    cycle(0, 1, 0, 1);
    check("b_done_ignores", 32'({MSB, LSB, Stopped, Running}), {14'd0, 8'd3, 8'd99, 2'b10});
    cycle(0, 0, 1, 0);

    // run / pause / resume
    ModeSel = 1'b0;
    cycle(1, 0, 0, 0);
    ticks(30);
    cycle(0, 1, 0, 0);
    ticks(50);
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    ticks(20);
    check("pause_lsb", 32'(LSB), 32'd50);
    check("pause_msb", 32'(MSB), 32'd0);
    cycle(0, 0, 1, 0);

    // simultaneous events at LSB=40
    cycle(1, 0, 0, 0);
    ticks(40);
    cycle(0, 1, 0, 1);
    check("pause_tick_lsb", 32'(LSB), 32'd40);
    check("pause_tick_state", 32'({Running, Stopped}), 32'd0);
    cycle(1, 0, 0, 1);
    check("resume_tick_lsb", 32'(LSB), 32'd40);
    check("resume_tick_run", 32'(Running), 32'd1);
    cycle(1, 0, 1, 1);
    check("clear_start", 32'({MSB, LSB, Running}), 32'd0);
    ticks(3);

    // full mode A run
    cycle(1, 0, 0, 0);
    ticks(9999);
    check("a_full", 32'({MSB, LSB, Stopped}), {15'd0, 8'd99, 8'd99, 1'b1});
    ticks(5);
    cycle(0, 0, 1, 0);
    check("a_clear", 32'({MSB, LSB, Stopped, Running, Pulse1Hz}), 32'd0);

    // randomized control mix
    for (int i = 0; i < 1500; i++) begin
      ModeSel     = 1'($urandom_range(0, 1));
      TimeControl = 3'($urandom_range(0, 7));
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0,
            $urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
    end
    cycle(0, 0, 1, 0);

    // asynchronous reset mid-run
    ModeSel = 1'b0;
    cycle(1, 0, 0, 0);
    ticks(520);
    check("pre_reset_msb", 32'(MSB), 32'd5);
    #3 nReset = 1'b0;
    #1;
    check("async_reset_out", 32'({MSB, LSB, Stopped, Running, Pulse1Hz}), 32'd0);
    model_reset();
    @(posedge CLK);
    #2 nReset = 1'b1;
    ticks(10);
    check("post_reset_idle", 32'({MSB, LSB, Running}), 32'd0);
    cycle(1, 0, 0, 0);
    ticks(7);
    check("post_reset_count", 32'(LSB), 32'd7);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 Parameter TICK_DIV, default 1, SHALL mean the number of Tick100Hz pulses per LSB increment.
REQ-002 CLK  input  1  single system clock; all state SHALL change on its rising edge only.
REQ-003 nReset  input  1  reset, asynchronous, active-low.
REQ-004 Tick100Hz  input  1  one-CLK-wide enable pulse at 100 Hz.
REQ-005 Start  input  1  one-CLK pulse; start or resume.
REQ-006 Pause  input  1  one-CLK pulse; pause.
REQ-007 Clear  input  1  one-CLK pulse; abort and zero.
REQ-008 ModeSel  input  1  0 = Mode A (count to 99.99 s), 1 = Mode B (count to TimeControl+1 s).
REQ-009 TimeControl  input  3  Mode B target seconds minus 1.
REQ-010 MSB  output  8  elapsed seconds, binary, 0..99.
REQ-011 LSB  output  8  elapsed hundredths, binary, 0..99.
REQ-012 Stopped  output  1  high while the count has reached its terminal value.
REQ-013 Running  output  1  high in RUN state only.
REQ-014 Pulse1Hz  output  1  registered square wave: 1 when LSB >= 50 and state is RUN or PAUSE, else 0.

Function
REQ-015 FSM states SHALL be IDLE, RUN, PAUSE, DONE.
REQ-016 IDLE: MSB = LSB = 0; Start -> RUN, latching ModeSel and TimeControl on that edge.
REQ-017 ModeSel/TimeControl changes outside IDLE SHALL be ignored (latched copies used).
REQ-018 RUN: every TICK_DIV-th Tick100Hz SHALL increment LSB; LSB 99 -> 0 with MSB +1 on the same edge.
REQ-019 Terminal value SHALL be MSB=99, LSB=99 (Mode A) or MSB=TimeControl+1, LSB=99 (Mode B).
REQ-020 The tick edge that loads the terminal value SHALL move the FSM to DONE; Stopped SHALL be high from that same edge.
REQ-021 RUN: Pause -> PAUSE; PAUSE: Start -> RUN; ticks in PAUSE, IDLE and DONE SHALL be ignored, and the tick-divider count SHALL be held in PAUSE.
REQ-022 DONE: MSB/LSB held at the terminal value; only Clear leaves DONE (-> IDLE).
REQ-023 Clear in any state SHALL go to IDLE and zero MSB, LSB and the tick divider on that edge.
REQ-024 Simultaneous events: Clear beats Start/Pause/tick; in RUN, Pause beats tick (no increment); in PAUSE, Start and a tick on the same edge SHALL resume without incrementing.
REQ-025 Start in RUN or DONE, and Pause in IDLE, PAUSE or DONE, SHALL be ignored.
REQ-026 MSB SHALL never exceed 99; LSB SHALL never exceed 99.
REQ-027 All outputs SHALL be registered; there is no combinational input-to-output path.

Reset
REQ-028 nReset low SHALL asynchronously force IDLE, MSB=0, LSB=0, Stopped=0, Running=0, Pulse1Hz=0, divider=0, and latched mode/TimeControl=0.
REQ-029 Reset asserted mid-count SHALL discard the count; after release, the block SHALL wait in IDLE for Start.

Structure
REQ-030 Shared package timer_pkg SHALL hold the state enum, LSB_MAX=99, MSB_MAX_A=99 and BLINK_THRESH=50.
REQ-031 One sub-module, mod100_counter (8-bit, 0..99, enable, clear, carry-out), SHALL be instantiated twice for LSB and MSB.

Verification
REQ-032 Reset, Start, ModeSel=0, 150 ticks -> MSB=1, LSB=50, Pulse1Hz=1, Running=1.
REQ-033 ModeSel=1, TimeControl=2, Start, 399 ticks -> MSB=3, LSB=99, Stopped=1 on that edge; 10 further ticks -> no change.
REQ-034 Mode A, Start, 30 ticks, Pause, 50 ticks, Start, 20 ticks -> LSB=50, MSB=0.
REQ-035 Mode A run to 9999 ticks -> MSB=99, LSB=99, Stopped=1; Clear -> all outputs 0 and IDLE next edge.
REQ-036 RUN at LSB=40: Pause and tick on the same edge -> LSB stays 40, state PAUSE; Clear and Start on the same edge -> IDLE.
REQ-037 nReset pulsed low asynchronously mid-RUN (MSB=5) -> outputs 0 immediately; Start then required to count.
